// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and byte-wide RAM signals seen by mem_port_arbiter.
interface mem_port_arbiter_if;
    // Instruction fetch port
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_clear;
    logic        if_done;
    logic [31:0] if_rdata;
    // Load/store port
    logic        mem_req;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [1:0]  mem_len;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    // Byte-wide RAM port
    logic [31:0] ram_a;
    logic [7:0]  ram_dout;
    logic        ram_wr;
    logic [7:0]  ram_din;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, if_clear, mem_req, mem_rw, mem_addr, mem_len, mem_wdata,
               ram_din,
        output if_done, if_rdata, mem_done, mem_rdata, ram_a, ram_dout, ram_wr
    );

    // Requester / RAM side
    modport master (
        output if_req, if_addr, if_clear, mem_req, mem_rw, mem_addr, mem_len, mem_wdata,
               ram_din,
        input  if_done, if_rdata, mem_done, mem_rdata, ram_a, ram_dout, ram_wr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a load/store port onto a single byte-wide RAM.
// Transfers run one byte per cycle, little-endian; a one-cycle GAP follows every
// completed or aborted transaction.
module mem_port_arbiter (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);

    typedef enum logic [2:0] {StIdle, StIfRd, StMemRd, StMemWr, StGap} state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;          // index of the byte whose address is on ram_a
    logic [1:0]  nlast_q, nlast_d;      // index of the final byte (N-1)
    logic        last_mem_q, last_mem_d; // 1: previous grant went to the load/store port
    logic [31:0] wdata_q, wdata_d;
    logic [23:0] rbuf_q, rbuf_d;        // bytes 0..2 of a read; the final byte bypasses it
    logic        if_done_q, if_done_d;
    logic        mem_done_q, mem_done_d;
    logic [31:0] ram_a_q, ram_a_d;
    logic [7:0]  ram_dout_q, ram_dout_d;
    logic        ram_wr_q, ram_wr_d;

    logic        if_pend, grant_mem, grant_if, done_now;
    logic [1:0]  cnt_inc;
    logic [31:0] rd_word;

    // A cleared fetch is not eligible; MEM wins unless both wait and MEM went last
    assign if_pend   = bus.if_req & ~bus.if_clear;
    assign grant_mem = bus.mem_req & (~if_pend | ~last_mem_q);
    assign grant_if  = if_pend & ~grant_mem;
    assign done_now  = if_done_q | mem_done_q;
    assign cnt_inc   = cnt_q + 2'd1;

    // The final byte is still on ram_din during the done cycle, so merge it here
    assign rd_word = {8'h00, rbuf_q} | ({24'h000000, bus.ram_din} << {nlast_q, 3'b000});

    assign bus.if_done   = if_done_q;
    assign bus.mem_done  = mem_done_q;
    assign bus.if_rdata  = if_done_q  ? rd_word : 32'h0;
    assign bus.mem_rdata = mem_done_q ? rd_word : 32'h0;
    assign bus.ram_a     = ram_a_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.ram_wr    = ram_wr_q;

    // Next-state, arbitration and byte sequencing
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        nlast_d    = nlast_q;
        last_mem_d = last_mem_q;
        wdata_d    = wdata_q;
        rbuf_d     = rbuf_q;
        if_done_d  = 1'b0;
        mem_done_d = 1'b0;
        ram_a_d    = ram_a_q;
        ram_dout_d = ram_dout_q;
        ram_wr_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (grant_mem) begin
                    state_d    = bus.mem_rw ? StMemWr : StMemRd;
                    last_mem_d = 1'b1;
                    cnt_d      = 2'd0;
                    unique case (bus.mem_len)
                        2'b00:   nlast_d = 2'd0;
                        2'b01:   nlast_d = 2'd1;
                        default: nlast_d = 2'd3;
                    endcase
                    wdata_d    = bus.mem_wdata;
                    rbuf_d     = 24'h0;
                    ram_a_d    = bus.mem_addr;
                    ram_dout_d = bus.mem_wdata[7:0];
                    ram_wr_d   = bus.mem_rw;
                end else if (grant_if) begin
                    state_d    = StIfRd;
                    last_mem_d = 1'b0;
                    cnt_d      = 2'd0;
                    nlast_d    = 2'd3;
                    rbuf_d     = 24'h0;
                    ram_a_d    = bus.if_addr;
                end
            end
            StIfRd, StMemRd: begin
                if ((state_q == StIfRd && bus.if_clear) || done_now) begin
                    state_d = StGap;
                end else begin
                    // ram_din holds the byte addressed one cycle earlier
                    unique case (cnt_q)
                        2'd1:    rbuf_d[7:0]   = bus.ram_din;
                        2'd2:    rbuf_d[15:8]  = bus.ram_din;
                        2'd3:    rbuf_d[23:16] = bus.ram_din;
                        default: ;
                    endcase
                    if (cnt_q == nlast_q) begin
                        if_done_d  = (state_q == StIfRd);
                        mem_done_d = (state_q == StMemRd);
                    end else begin
                        cnt_d   = cnt_inc;
                        ram_a_d = ram_a_q + 32'd1;
                    end
                end
            end
            StMemWr: begin
                if (done_now) begin
                    state_d = StGap;
                end else if (cnt_q == nlast_q) begin
                    mem_done_d = 1'b1;
                end else begin
                    cnt_d      = cnt_inc;
                    ram_a_d    = ram_a_q + 32'd1;
                    ram_dout_d = wdata_q[{cnt_inc, 3'b000} +: 8];
                    ram_wr_d   = 1'b1;
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset; reset also aborts any transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= 2'd0;
            nlast_q    <= 2'd0;
            last_mem_q <= 1'b0;
            wdata_q    <= 32'h0;
            rbuf_q     <= 24'h0;
            if_done_q  <= 1'b0;
            mem_done_q <= 1'b0;
            ram_a_q    <= 32'h0;
            ram_dout_q <= 8'h0;
            ram_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            nlast_q    <= nlast_d;
            last_mem_q <= last_mem_d;
            wdata_q    <= wdata_d;
            rbuf_q     <= rbuf_d;
            if_done_q  <= if_done_d;
            mem_done_q <= mem_done_d;
            ram_a_q    <= ram_a_d;
            ram_dout_q <= ram_dout_d;
            ram_wr_q   <= ram_wr_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: RAM model, per-port scoreboards,
// a vector table of single transactions and hand-written corner sequences.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM model: one-cycle read latency, write on ram_wr ----------
    logic [7:0] ram [int unsigned];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        bus.ram_din <= ram_rd(bus.ram_a);
        if (bus.ram_wr === 1'b1) ram[bus.ram_a] = bus.ram_dout;
    end

    // ---------------- Scoreboards ------------------------------------------------
    typedef struct {
        bit          chk;   // compare rdata (loads and fetches only)
        logic [31:0] exp;
    } sb_t;

    sb_t if_sb[$];
    sb_t mem_sb[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.if_done || bus.mem_done) begin
                check("done_exclusive", {31'h0, bus.if_done & bus.mem_done}, 32'h0);
                check("ram_wr_at_done", {31'h0, bus.ram_wr}, 32'h0);
            end
            if (bus.if_done) begin
                if (if_sb.size() == 0) begin
                    check("if_done_unexpected", 32'h1, 32'h0);
                end else begin
                    sb_t e;
                    e = if_sb.pop_front();
                    check("if_rdata", bus.if_rdata, e.exp);
                end
            end
            if (bus.mem_done) begin
                if (mem_sb.size() == 0) begin
                    check("mem_done_unexpected", 32'h1, 32'h0);
                end else begin
                    sb_t e;
                    e = mem_sb.pop_front();
                    if (e.chk) check("mem_rdata", bus.mem_rdata, e.exp);
                end
            end
        end
    end

    // ---------------- Vector table -----------------------------------------------
    typedef struct {
        string       name;
        bit          is_if;
        bit          rw;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    function automatic int nbytes(input vec_t v);
        if (v.is_if) return 4;
        case (v.len)
            2'b00:   return 1;
            2'b01:   return 2;
            default: return 4;
        endcase
    endfunction

    // Drives one transaction from an IDLE cycle, checks per-cycle RAM traffic,
    // latency and written bytes, then waits out GAP so the next call starts in IDLE.
    task automatic run_vec(input vec_t v);
        int   n;
        int   wr_cnt;
        bit   seen;
        sb_t  e;
        n      = nbytes(v);
        wr_cnt = 0;
        seen   = 1'b0;
        e.chk  = !v.rw;
        e.exp  = v.exp;
        if (v.is_if) begin
            if_sb.push_back(e);
            bus.if_addr = v.addr;
            bus.if_req  = 1'b1;
        end else begin
            mem_sb.push_back(e);
            bus.mem_rw    = v.rw;
            bus.mem_addr  = v.addr;
            bus.mem_len   = v.len;
            bus.mem_wdata = v.wdata;
            bus.mem_req   = 1'b1;
        end
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(negedge clk);
            // Requester wiggles the inputs mid-transfer; the latched values must win
            bus.mem_addr  = 32'hFFFF_FFF0;
            bus.mem_wdata = 32'h5555_5555;
            bus.if_addr   = 32'hFFFF_FF00;
            if (c <= n) begin
                check({v.name, "_ram_a"}, bus.ram_a, v.addr + 32'(c - 1));
                check({v.name, "_ram_wr"}, {31'h0, bus.ram_wr}, {31'h0, v.rw});
                if (v.rw) begin
                    check({v.name, "_ram_dout"}, {24'h0, bus.ram_dout},
                          {24'h0, v.wdata[8*(c-1) +: 8]});
                end
            end
            if (bus.ram_wr) wr_cnt++;
            if ((v.is_if && bus.if_done) || (!v.is_if && bus.mem_done)) begin
                seen = 1'b1;
                check({v.name, "_latency"}, c, n + 1);
            end
        end
        if (!seen) check({v.name, "_timeout"}, 32'h0, 32'h1);
        bus.if_req  = 1'b0;
        bus.mem_req = 1'b0;
        @(negedge clk);
        check({v.name, "_gap_wr"}, {31'h0, bus.ram_wr}, 32'h0);
        @(negedge clk);
        if (v.rw) begin
            check({v.name, "_wr_cycles"}, wr_cnt, n);
            for (int k = 0; k < n; k++) begin
                check({v.name, "_ram_byte"}, {24'h0, ram_rd(v.addr + 32'(k))},
                      {24'h0, v.wdata[8*k +: 8]});
            end
        end
    endtask

    vec_t vecs[$];

    initial begin
        int order[$];
        bit reraise;
        bit seen;

        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.if_clear  = 1'b0;
        bus.mem_req   = 1'b0;
        bus.mem_rw    = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_len   = 2'b00;
        bus.mem_wdata = 32'h0;

        ram[32'h100] = 8'h13;
        ram[32'h101] = 8'h00;
        ram[32'h102] = 8'h00;
        ram[32'h103] = 8'h00;
        ram[32'h11]  = 8'h80;
        ram[32'h12]  = 8'hFF;

        // name, is_if, rw, addr, len, wdata, expected rdata
        vecs.push_back('{"fetch_100",   1'b1, 1'b0, 32'h100,  2'b10, 32'h0,        32'h0000_0013});
        vecs.push_back('{"st_word",     1'b0, 1'b1, 32'h2000, 2'b10, 32'hDEADBEEF, 32'h0});
        vecs.push_back('{"ld_word",     1'b0, 1'b0, 32'h2000, 2'b10, 32'h0,        32'hDEAD_BEEF});
        vecs.push_back('{"ld_half",     1'b0, 1'b0, 32'h11,   2'b01, 32'h0,        32'h0000_FF80});
        vecs.push_back('{"ld_byte",     1'b0, 1'b0, 32'h11,   2'b00, 32'h0,        32'h0000_0080});
        vecs.push_back('{"st_byte",     1'b0, 1'b1, 32'h3001, 2'b00, 32'h123456AA, 32'h0});
        vecs.push_back('{"ld_after_sb", 1'b0, 1'b0, 32'h3000, 2'b10, 32'h0,        32'h0000_AA00});
        vecs.push_back('{"st_half",     1'b0, 1'b1, 32'h3002, 2'b01, 32'h9999C3D4, 32'h0});
        vecs.push_back('{"ld_len11",    1'b0, 1'b0, 32'h3000, 2'b11, 32'h0,        32'hC3D4_AA00});
        vecs.push_back('{"ld_half_un",  1'b0, 1'b0, 32'h2001, 2'b01, 32'h0,        32'h0000_ADBE});
        vecs.push_back('{"fetch_2000",  1'b1, 1'b0, 32'h2000, 2'b10, 32'h0,        32'hDEAD_BEEF});

        // ---- Reset state ----
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_if_done",   {31'h0, bus.if_done},  32'h0);
        check("rst_mem_done",  {31'h0, bus.mem_done}, 32'h0);
        check("rst_if_rdata",  bus.if_rdata,  32'h0);
        check("rst_mem_rdata", bus.mem_rdata, 32'h0);
        check("rst_ram_a",     bus.ram_a,     32'h0);
        check("rst_ram_dout",  {24'h0, bus.ram_dout}, 32'h0);
        check("rst_ram_wr",    {31'h0, bus.ram_wr},   32'h0);
        rst = 1'b0;
        @(negedge clk);

        // ---- Arbitration: simultaneous requests, then MEM re-raised ----
        if_sb.push_back('{1'b1, 32'h0000_0013});
        mem_sb.push_back('{1'b1, 32'h0000_0080});
        bus.if_addr  = 32'h100;
        bus.mem_rw   = 1'b0;
        bus.mem_addr = 32'h11;
        bus.mem_len  = 2'b00;
        bus.if_req   = 1'b1;
        bus.mem_req  = 1'b1;
        reraise      = 1'b0;
        for (int c = 0; c < 60 && order.size() < 3; c++) begin
            @(negedge clk);
            if (reraise) begin
                mem_sb.push_back('{1'b1, 32'h0000_00FF});
                bus.mem_addr = 32'h12;
                bus.mem_req  = 1'b1;
                reraise      = 1'b0;
            end
            if (bus.mem_done) begin
                order.push_back(1);
                bus.mem_req = 1'b0;
                if (order.size() == 1) reraise = 1'b1;
            end
            if (bus.if_done) begin
                order.push_back(0);
                bus.if_req = 1'b0;
            end
        end
        check("arb_count", order.size(), 3);
        if (order.size() == 3) begin
            check("arb_first_mem",  order[0], 1);
            check("arb_second_if",  order[1], 0);
            check("arb_third_mem",  order[2], 1);
        end
        repeat (2) @(negedge clk);

        // ---- Table-driven single transactions ----
        foreach (vecs[i]) run_vec(vecs[i]);

        // ---- if_clear during fetch byte 2, with a MEM request waiting ----
        bus.if_addr = 32'h100;
        bus.if_req  = 1'b1;
        seen        = 1'b0;
        for (int c = 1; c <= 12 && !seen; c++) begin
            @(negedge clk);
            if (c == 3) begin
                check("clr_ram_a_b2", bus.ram_a, 32'h102);
                bus.if_clear = 1'b1;
                mem_sb.push_back('{1'b1, 32'h0000_0080});
                bus.mem_rw   = 1'b0;
                bus.mem_addr = 32'h11;
                bus.mem_len  = 2'b00;
                bus.mem_req  = 1'b1;
            end
            if (c == 4) begin
                check("clr_ram_a_stops", bus.ram_a, 32'h102);
                check("clr_no_if_done", {31'h0, bus.if_done}, 32'h0);
                bus.if_clear = 1'b0;
                bus.if_req   = 1'b0;
            end
            if (c == 6) check("clr_mem_grant_a", bus.ram_a, 32'h11);
            if (bus.mem_done) begin
                seen = 1'b1;
                check("clr_mem_done_cycle", c, 7);
            end
        end
        if (!seen) check("clr_mem_timeout", 32'h0, 32'h1);
        bus.mem_req = 1'b0;
        repeat (2) @(negedge clk);

        // ---- Reset during byte 1 of a word store ----
        bus.mem_rw    = 1'b1;
        bus.mem_addr  = 32'h4000;
        bus.mem_len   = 2'b10;
        bus.mem_wdata = 32'hCAFE_F00D;
        bus.mem_req   = 1'b1;
        @(negedge clk);
        check("rstw_b0_wr", {31'h0, bus.ram_wr}, 32'h1);
        @(negedge clk);
        check("rstw_b1_a", bus.ram_a, 32'h4001);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_wr_off", {31'h0, bus.ram_wr}, 32'h0);
        check("rstw_ram_a",  bus.ram_a, 32'h0);
        check("rstw_no_done", {31'h0, bus.mem_done}, 32'h0);
        rst         = 1'b0;
        bus.mem_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rstw_idle_wr", {31'h0, bus.ram_wr}, 32'h0);
        end
        check("rstw_byte0_kept", {24'h0, ram_rd(32'h4000)}, 32'h0000_000D);
        check("rstw_byte1_kept", {24'h0, ram_rd(32'h4001)}, 32'h0000_00F0);
        check("rstw_byte2_none", {24'h0, ram_rd(32'h4002)}, 32'h0);
        run_vec('{"ld_after_rst", 1'b0, 1'b0, 32'h4000, 2'b10, 32'h0, 32'h0000_F00D});

        check("sb_if_empty",  if_sb.size(),  0);
        check("sb_mem_empty", mem_sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 clk  in  1  clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 if_req  in  1  fetch request, level, held until if_done; if_addr in 32: word fetch address.
REQ-004 if_clear  in  1  abort the current/pending fetch (branch redirect).
REQ-005 if_done  out  1  one-cycle pulse, fetch complete; if_rdata out 32: fetched word, valid only while if_done=1.
REQ-006 mem_req  in  1  load/store request, level, held until mem_done; mem_rw in 1: 0=load, 1=store.
REQ-007 mem_addr in 32 byte address; mem_len in 2: 00=byte, 01=half, 10=word, 11=treated as word; mem_wdata in 32 store data.
REQ-008 mem_done  out  1  one-cycle pulse, transaction complete; mem_rdata out 32: load data, zero-extended, valid only while mem_done=1.
REQ-009 ram_a out 32, ram_dout out 8, ram_wr out 1 (1=write): byte-wide RAM port, all registered.
REQ-010 ram_din  in  8  RAM read data; byte for the address presented in cycle t is valid in cycle t+1.

Function
REQ-011 States: IDLE, IF_RD, MEM_RD, MEM_WR, GAP; byte counter cnt (0..3); last_grant flag (IF/MEM).
REQ-012 Arbitration in IDLE only; no preemption of a granted transaction.
REQ-013 Priority: MEM over IF, except when both pending and last_grant=MEM, then IF wins.
REQ-014 On grant, address, length, rw and wdata are latched; later changes on request inputs are ignored until done.
REQ-015 Byte count N: IF=4; MEM per mem_len (1/2/4); bytes accessed little-endian at addr, addr+1, ... addr+N-1.
REQ-016 Read: byte k address on ram_a in cycle G+1+k (G = grant edge cycle), ram_wr=0; byte k captured from ram_din in cycle G+2+k into rdata bits [8k+7:8k].
REQ-017 Read done pulse asserted in cycle G+N+1 (cycle the last byte is captured); IF word fetch = 5 cycles from grant.
REQ-018 Write: byte k on ram_a/ram_dout with ram_wr=1 in cycle G+1+k; mem_done in cycle G+N+1 with ram_wr=0.
REQ-019 After any done pulse, state GAP for exactly one cycle; requests ignored in GAP; then IDLE.
REQ-020 ram_wr SHALL be 1 only in MEM_WR byte cycles; never during reads, GAP or IDLE.
REQ-021 if_clear in IF_RD: transaction aborted next edge, no if_done, go to GAP; if_clear in IDLE with if_req=1: request not granted that cycle.
REQ-022 if_clear SHALL NOT affect MEM_RD/MEM_WR.
REQ-023 Unused upper mem_rdata bits for byte/half loads SHALL be 0; sign extension is the requester's job.
REQ-024 if_done and mem_done never asserted in the same cycle.

Reset
REQ-025 rst=1: state IDLE, cnt=0, last_grant=IF, if_done=mem_done=0, if_rdata=mem_rdata=0, ram_a=0, ram_dout=0, ram_wr=0.
REQ-026 rst mid-transaction: abort immediately, no done pulse, outputs as REQ-025 next cycle; stores partially written stay written.

Verification
REQ-027 IF fetch addr 0x100, RAM bytes 13,00,00,00 -> ram_a 0x100..0x103, if_done 5 cycles after grant, if_rdata=0x00000013.
REQ-028 Store word 0xDEADBEEF @0x2000 -> ram_wr=1 four cycles, bytes EF,BE,AD,DE at 0x2000..0x2003, mem_done next cycle, then GAP.
REQ-029 Load half @0x11 from bytes 0x80,0xFF -> mem_rdata=0x0000FF80; load byte -> 0x00000080.
REQ-030 if_req and mem_req raised same cycle, last_grant=IF -> MEM served first, GAP, then IF; repeat with MEM re-raised -> IF served before second MEM.
REQ-031 if_clear during IF_RD byte 2 -> no if_done, ram_a stops, GAP then IDLE; pending MEM granted next.
REQ-032 rst asserted during MEM_WR byte 1 of word store -> ram_wr=0 next cycle, no mem_done, IDLE.
